imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 33 +++
 rtl/imem_word_assembler.sv | 52 +++++
 rtl/imem_loader.sv | 164 ++++++++++++++++
 tb/tb_imem_loader.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared types and constants for the instruction-memory loader.
//   state_e        : loader FSM state encoding (also driven on the debug port)
//   MEM_DEPTH_DEF  : default maximum number of loadable words
//   HDR_LEN        : number of header bytes (16-bit word count, low byte first)
//   ST_AFTER_DATA  : state entered after the last word has been written
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds the CHK state.
// -----------------------------------------------------------------------------
package imem_loader_pkg;

    localparam int MEM_DEPTH_DEF = 1001;
    localparam int HDR_LEN       = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHK    = 3'd4,
`endif
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_e;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_e ST_AFTER_DATA = ST_CHK;
`else
    localparam state_e ST_AFTER_DATA = ST_DONE;
`endif

endpackage

// File: rtl/imem_word_assembler.sv
// -----------------------------------------------------------------------------
// imem_word_assembler
// Collects four bytes (little-endian, first byte -> bits 7:0) into a 32-bit
// word. word_valid_o is a combinational pulse coinciding with the 4th byte.
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   clear_i         : synchronous clear of any partial word
//   byte_valid_i    : a byte is accepted this cycle
//   byte_i          : accepted byte
//   word_valid_o    : this byte completes a word
//   word_o          : completed word (valid with word_valid_o)
// -----------------------------------------------------------------------------
module imem_word_assembler (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] shift_q, shift_d;

    // Bytes enter at the top and move down, so after three bytes the first
    // one sits in bits 7:0 and the 4th byte completes bits 31:24.
    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (clear_i) begin
            cnt_d   = 2'd0;
            shift_d = 24'd0;
        end else if (byte_valid_i) begin
            cnt_d   = cnt_q + 2'd1;
            shift_d = {byte_i, shift_q[23:8]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= 2'd0;
            shift_q <= 24'd0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    assign word_valid_o = byte_valid_i && !clear_i && (cnt_q == 2'd3);
    assign word_o       = {byte_i, shift_q};

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Loads an instruction memory from a byte stream: 16-bit word count N (low
// byte first) followed by 4*N little-endian word bytes.
// Handshake: a byte transfers on a rising edge where rx_valid and rx_ready are
// both high; rx_ready depends only on the FSM state, never on rx_valid.
// Ports:
//   SYS_clk, SYS_reset : clock, asynchronous active-low reset
//   start              : one-cycle pulse, starts a load from IDLE/DONE/ERR
//   rx_valid, rx_data  : byte stream in;  rx_ready : byte stream ready
//   mem_we, mem_addr, mem_wdata : one-cycle write strobe, word index, word
//   busy               : load in progress (also holds the CPU in reset)
//   done, error        : sticky completion / failure flags until next start
//   words_loaded       : words written in the current load
//   dbg_state_o        : current FSM state
// Macro IMEM_LOADER_CHECKSUM_EN: a trailing byte must equal the XOR of all
// data bytes, checked in the CHK state.
// -----------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
    input  logic              SYS_clk,
    input  logic              SYS_reset,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       words_loaded,
    output logic [2:0]        dbg_state_o
);

    localparam logic [15:0] MAX_WORDS = 16'(MEM_DEPTH);

    state_e            state_q;
    logic [7:0]        n_lo_q;
    logic [15:0]       n_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic [15:0]       words_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        xor_q;
`endif

    logic        rx_fire;
    logic        idle_like;
    logic        load_start;
    logic        word_valid;
    logic [31:0] word;
    logic [15:0] n_d;

    assign rx_fire    = rx_valid && rx_ready;
    assign idle_like  = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR);
    assign load_start = start && idle_like;
    assign n_d        = {rx_data, n_lo_q};

    imem_word_assembler u_asm (
        .clk_i        (SYS_clk),
        .rst_ni       (SYS_reset),
        .clear_i      (load_start),
        .byte_valid_i (rx_fire && (state_q == ST_DATA)),
        .byte_i       (rx_data),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    always_ff @(posedge SYS_clk or negedge SYS_reset) begin
        if (!SYS_reset) begin
            state_q     <= ST_IDLE;
            n_lo_q      <= 8'd0;
            n_q         <= 16'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            words_q     <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q       <= 8'd0;
`endif
        end else begin
            mem_we_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state_q <= ST_LEN_LO;
                        words_q <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xor_q   <= 8'd0;
`endif
                    end
                end
                ST_LEN_LO: begin
                    if (rx_fire) begin
                        n_lo_q  <= rx_data;
                        state_q <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (rx_fire) begin
                        n_q <= n_d;
                        if (n_d == 16'd0) begin
                            state_q <= ST_AFTER_DATA;
                        end else if (n_d > MAX_WORDS) begin
                            state_q <= ST_ERR;
                        end else begin
                            state_q <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    if (rx_fire) begin
                        xor_q <= xor_q ^ rx_data;
                    end
`endif
                    // Write strobe is registered: it shows the cycle after the
                    // 4th byte, addressed by the pre-increment count.
                    if (word_valid) begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= words_q[ADDR_W-1:0];
                        mem_wdata_q <= word;
                        words_q     <= words_q + 16'd1;
                        if (words_q + 16'd1 == n_q) begin
                            state_q <= ST_AFTER_DATA;
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                ST_CHK: begin
                    if (rx_fire) begin
                        state_q <= (rx_data == xor_q) ? ST_DONE : ST_ERR;
                    end
                end
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    assign rx_ready = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                      (state_q == ST_DATA)   || (state_q == ST_CHK);
`else
    assign rx_ready = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                      (state_q == ST_DATA);
`endif
    assign busy         = rx_ready;
    assign done         = (state_q == ST_DONE);
    assign error        = (state_q == ST_ERR);
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign words_loaded = words_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;
  logic [2:0]  dbg_state;

  int tests_run;
  int tests_failed;
  int cyc;
  int wr_count;
  int last_addr;
  logic [31:0] mem [0:1023];
  logic [7:0]  run_xor;
  bit          gap_mode;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam int CHK_BYTES = 1;
`else
  localparam int CHK_BYTES = 0;
`endif

  imem_loader dut (
    .SYS_clk      (clk),
    .SYS_reset    (rst_n),
    .start        (start),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded),
    .dbg_state_o  (dbg_state)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // memory model: capture writes mid-cycle
  always @(negedge clk) begin
    if (mem_we) begin
      mem[mem_addr] = mem_wdata;
      wr_count++;
      last_addr = int'(mem_addr);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    int n;
    if (gap_mode) begin
      rx_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (!rx_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!rx_ready) begin
      tests_run++; tests_failed++;
      $display("FAIL send_byte_timeout: rx_ready got 0 expected 1");
    end else begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_hdr(input logic [15:0] n);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    send_byte(w[23:16]);
    send_byte(w[31:24]);
    run_xor = run_xor ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
  endtask

  // sends the checksum byte only when the checksum feature is built in
  task automatic finish_stream();
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(run_xor);
`endif
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_start();
    wr_count  = 0;
    last_addr = -1;
    run_xor   = 8'h00;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    tests_run++; if (rx_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_rx_ready: got %b expected 0", rx_ready); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests_run++; if (mem_we !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
    tests_run++; if ({done, error} !== 2'b00) begin tests_failed++; $display("FAIL reset_flags: got %b expected 00", {done, error}); end
    tests_run++; if (words_loaded !== 16'd0) begin tests_failed++; $display("FAIL reset_words: got %0d expected 0", words_loaded); end
    tests_run++; if (dbg_state !== 3'd0) begin tests_failed++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_basic();
    int c0;
    do_start();
    tests_run++; if (rx_ready !== 1'b1 || busy !== 1'b1) begin tests_failed++; $display("FAIL basic_ready: got %b%b expected 11", rx_ready, busy); end
    c0 = cyc;
    send_hdr(16'd2);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    run_xor = 8'h13;
    // write strobe the cycle after the 4th handshake
    tests_run++; if (mem_we !== 1'b1 || mem_addr !== 10'd0 || mem_wdata !== 32'h0000_0013) begin tests_failed++; $display("FAIL basic_we0: got we=%b addr=%0d data=%h expected we=1 addr=0 data=00000013", mem_we, mem_addr, mem_wdata); end
    tests_run++; if (words_loaded !== 16'd1) begin tests_failed++; $display("FAIL basic_words_at_we: got %0d expected 1", words_loaded); end
    send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    run_xor = run_xor ^ 8'h93 ^ 8'h10;
    finish_stream();
    tests_run++; if (cyc - c0 !== 10 + CHK_BYTES) begin tests_failed++; $display("FAIL basic_b2b_cycles: got %0d expected %0d", cyc - c0, 10 + CHK_BYTES); end
    idle(2);
    tests_run++; if (mem[0] !== 32'h0000_0013) begin tests_failed++; $display("FAIL basic_mem0: got %h expected 00000013", mem[0]); end
    tests_run++; if (mem[1] !== 32'h0010_0093) begin tests_failed++; $display("FAIL basic_mem1: got %h expected 00100093", mem[1]); end
    tests_run++; if (wr_count !== 2) begin tests_failed++; $display("FAIL basic_wr_count: got %0d expected 2", wr_count); end
    tests_run++; if (done !== 1'b1 || error !== 1'b0) begin tests_failed++; $display("FAIL basic_flags: got done=%b err=%b expected 1 0", done, error); end
    tests_run++; if (words_loaded !== 16'd2) begin tests_failed++; $display("FAIL basic_words: got %0d expected 2", words_loaded); end
    tests_run++; if (busy !== 1'b0 || rx_ready !== 1'b0) begin tests_failed++; $display("FAIL basic_idle_ready: got %b%b expected 00", busy, rx_ready); end
    // bytes offered while not ready are not consumed and change nothing
    rx_valid = 1'b1; rx_data = 8'h55;
    repeat (3) begin @(posedge clk); #1; end
    rx_valid = 1'b0;
    tests_run++; if (done !== 1'b1 || words_loaded !== 16'd2 || wr_count !== 2) begin tests_failed++; $display("FAIL ignored_rx: got done=%b words=%0d writes=%0d expected 1 2 2", done, words_loaded, wr_count); end
  endtask

  task automatic test_zero_len();
    do_start();
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL zero_done_cleared: got %b expected 0", done); end
    send_hdr(16'd0);
    finish_stream();
    idle(2);
    tests_run++; if (done !== 1'b1 || error !== 1'b0) begin tests_failed++; $display("FAIL zero_flags: got done=%b err=%b expected 1 0", done, error); end
    tests_run++; if (wr_count !== 0) begin tests_failed++; $display("FAIL zero_writes: got %0d expected 0", wr_count); end
  endtask

  task automatic test_overflow();
    do_start();
    send_hdr(16'h03EA);
    idle(2);
    tests_run++; if (error !== 1'b1 || done !== 1'b0) begin tests_failed++; $display("FAIL ovf_flags: got err=%b done=%b expected 1 0", error, done); end
    tests_run++; if (wr_count !== 0 || words_loaded !== 16'd0) begin tests_failed++; $display("FAIL ovf_writes: got %0d/%0d expected 0/0", wr_count, words_loaded); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL ovf_busy: got %b expected 0", busy); end
  endtask

  task automatic test_max_len();
    int errs;
    logic [15:0] iv;
    do_start();
    tests_run++; if (error !== 1'b0) begin tests_failed++; $display("FAIL max_err_cleared: got %b expected 0", error); end
    send_hdr(16'h03E9);
    for (int i = 0; i < 1001; i++) begin
      iv = 16'(i);
      send_word({iv, ~iv});
    end
    finish_stream();
    idle(2);
    errs = 0;
    for (int i = 0; i < 1001; i++) begin
      iv = 16'(i);
      if (mem[i] !== {iv, ~iv}) errs++;
    end
    tests_run++; if (wr_count !== 1001) begin tests_failed++; $display("FAIL max_writes: got %0d expected 1001", wr_count); end
    tests_run++; if (last_addr !== 1000) begin tests_failed++; $display("FAIL max_last_addr: got %0d expected 1000", last_addr); end
    tests_run++; if (errs !== 0) begin tests_failed++; $display("FAIL max_contents: got %0d bad words expected 0", errs); end
    tests_run++; if (done !== 1'b1 || words_loaded !== 16'd1001) begin tests_failed++; $display("FAIL max_done: got done=%b words=%0d expected 1 1001", done, words_loaded); end
  endtask

  task automatic test_reset_mid();
    do_start();
    send_hdr(16'd4);
    send_word(32'h1111_1111);
    send_word(32'h2222_2222);
    send_word(32'h3333_3333);
    send_byte(8'hAB); send_byte(8'hCD);
    idle(1);
    tests_run++; if (wr_count !== 3) begin tests_failed++; $display("FAIL mid_pre_writes: got %0d expected 3", wr_count); end
    #2 rst_n = 1'b0;
    #1;
    tests_run++; if ({rx_ready, busy, mem_we, done, error} !== 5'b0) begin tests_failed++; $display("FAIL mid_reset_bits: got %b expected 00000", {rx_ready, busy, mem_we, done, error}); end
    tests_run++; if (words_loaded !== 16'd0 || mem_addr !== 10'd0 || mem_wdata !== 32'd0) begin tests_failed++; $display("FAIL mid_reset_regs: got words=%0d addr=%0d data=%h expected 0 0 0", words_loaded, mem_addr, mem_wdata); end
    @(posedge clk); #1 rst_n = 1'b1;
    idle(1);
    do_start();
    send_hdr(16'd1);
    send_word(32'hCAFE_F00D);
    finish_stream();
    idle(2);
    tests_run++; if (mem[0] !== 32'hCAFE_F00D || last_addr !== 0) begin tests_failed++; $display("FAIL mid_reload: got mem0=%h addr=%0d expected cafef00d 0", mem[0], last_addr); end
    tests_run++; if (done !== 1'b1 || words_loaded !== 16'd1 || wr_count !== 1) begin tests_failed++; $display("FAIL mid_reload_done: got done=%b words=%0d writes=%0d expected 1 1 1", done, words_loaded, wr_count); end
  endtask

  task automatic test_start_ignored_and_gaps();
    do_start();
    send_hdr(16'd2);
    start = 1'b1;
    send_byte(8'h13);
    start = 1'b0;
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    start = 1'b1;
    send_byte(8'h93);
    start = 1'b0;
    send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    run_xor = 8'h13 ^ 8'h93 ^ 8'h10;
    finish_stream();
    idle(2);
    tests_run++; if (mem[0] !== 32'h0000_0013 || mem[1] !== 32'h0010_0093 || wr_count !== 2) begin tests_failed++; $display("FAIL start_ignored: got %h %h writes=%0d expected 00000013 00100093 2", mem[0], mem[1], wr_count); end
    // same stream with random valid gaps must write the same words
    gap_mode = 1'b1;
    mem[0] = 32'd0; mem[1] = 32'd0;
    do_start();
    send_hdr(16'd2);
    send_word(32'h0000_0013);
    send_word(32'h0010_0093);
    finish_stream();
    gap_mode = 1'b0;
    idle(2);
    tests_run++; if (mem[0] !== 32'h0000_0013 || mem[1] !== 32'h0010_0093 || wr_count !== 2) begin tests_failed++; $display("FAIL gaps_words: got %h %h writes=%0d expected 00000013 00100093 2", mem[0], mem[1], wr_count); end
    tests_run++; if (done !== 1'b1 || words_loaded !== 16'd2) begin tests_failed++; $display("FAIL gaps_done: got done=%b words=%0d expected 1 2", done, words_loaded); end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    do_start();
    send_hdr(16'd1);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    send_byte(8'h00);
    idle(2);
    tests_run++; if (done !== 1'b1 || error !== 1'b0) begin tests_failed++; $display("FAIL chk_good: got done=%b err=%b expected 1 0", done, error); end
    tests_run++; if (mem[0] !== 32'hDDCC_BBAA) begin tests_failed++; $display("FAIL chk_good_mem: got %h expected ddccbbaa", mem[0]); end
    do_start();
    send_hdr(16'd1);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    send_byte(8'h01);
    idle(2);
    tests_run++; if (error !== 1'b1 || done !== 1'b0) begin tests_failed++; $display("FAIL chk_bad: got err=%b done=%b expected 1 0", error, done); end
    tests_run++; if (mem[0] !== 32'hDDCC_BBAA || words_loaded !== 16'd1) begin tests_failed++; $display("FAIL chk_bad_kept: got %h words=%0d expected ddccbbaa 1", mem[0], words_loaded); end
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    cyc          = 0;
    wr_count     = 0;
    last_addr    = -1;
    run_xor      = 8'h00;
    gap_mode     = 1'b0;
    start        = 1'b0;
    rx_valid     = 1'b0;
    rx_data      = 8'h00;
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    test_reset();
    test_basic();
    test_zero_len();
    test_overflow();
    test_max_len();
    test_reset_mid();
    test_start_ignored_and_gaps();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
